// File: rtl/sa_run_if.sv
// sa_run_if: host/array-facing signal bundle for sa_run_controller.
//   slave  : controller side (job queue in, array drive out, results out)
//   master : host / bench side (mirror of slave)
interface sa_run_if #(
  parameter int M_W   = 9,
  parameter int K_W   = 9,
  parameter int N_W   = 9,
  parameter int ID_W  = 4,
  parameter int CYC_W = 32
);
  logic             go;
  logic             stall_en;
  logic             job_valid;
  logic             job_ready;
  logic [M_W-1:0]   job_m;
  logic [K_W-1:0]   job_k;
  logic [N_W-1:0]   job_n;
  logic             start;
  logic             stall;
  logic [M_W-1:0]   m_size;
  logic [K_W-1:0]   k_size;
  logic [N_W-1:0]   n_size;
  logic             is_finished;
  logic             done_valid;
  logic [ID_W-1:0]  done_id;
  logic [CYC_W-1:0] done_cycles;
  logic             done_timeout;
  logic             busy;
  logic [CYC_W-1:0] total_cycles;

  modport slave (
    input  go, stall_en, job_valid, job_m, job_k, job_n, is_finished,
    output job_ready, start, stall, m_size, k_size, n_size,
           done_valid, done_id, done_cycles, done_timeout, busy, total_cycles
  );

  modport master (
    output go, stall_en, job_valid, job_m, job_k, job_n, is_finished,
    input  job_ready, start, stall, m_size, k_size, n_size,
           done_valid, done_id, done_cycles, done_timeout, busy, total_cycles
  );
endinterface

// File: rtl/sa_run_controller.sv
// sa_run_controller: job sequencer + performance monitor for the systolic array.
// Queues (M,K,N) jobs, launches them one at a time (START level + sizes),
// counts RUN cycles, aborts on a watchdog, optionally injects periodic STALL,
// and reports one DONE pulse per job plus a saturating running total.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : sa_run_if.slave (job queue, array drive, result reporting)
module sa_run_controller #(
  parameter int MAX_M_SIZE_LOG2   = 9,
  parameter int MAX_K_SIZE_LOG2   = 9,
  parameter int MAX_N_SIZE_LOG2   = 9,
  parameter int QDEPTH_LOG2       = 2,
  parameter int CYC_BWIDTH        = 32,
  parameter int TIMEOUT_CYCLES    = 50000,
  parameter int STALL_PERIOD_LOG2 = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  sa_run_if.slave bus
);
  localparam int DEPTH = 1 << QDEPTH_LOG2;
  localparam int ID_W  = QDEPTH_LOG2 + 2;
  localparam logic [QDEPTH_LOG2:0]  FULL    = (QDEPTH_LOG2+1)'(DEPTH);
  localparam logic [CYC_BWIDTH-1:0] CYC_MAX = '1;
  localparam logic [CYC_BWIDTH-1:0] TO_VAL  = CYC_BWIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, RETIRE, GAP} state_t;

  // ---------------- job queue ----------------
  logic [MAX_M_SIZE_LOG2-1:0] q_m [DEPTH];
  logic [MAX_K_SIZE_LOG2-1:0] q_k [DEPTH];
  logic [MAX_N_SIZE_LOG2-1:0] q_n [DEPTH];
  logic [QDEPTH_LOG2-1:0]     wr_ptr, rd_ptr;
  logic [QDEPTH_LOG2:0]       count, count_nxt;
  logic                       job_ready_q;
  logic                       push, pop;

  state_t                     state;

  // job_ready_q is registered !full, so a pop in the same cycle cannot
  // open room for a push into a full queue.
  assign push = bus.job_valid && job_ready_q;
  assign pop  = (state == IDLE) && bus.go && (count != '0);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_m[wr_ptr] <= bus.job_m;
      q_k[wr_ptr] <= bus.job_k;
      q_n[wr_ptr] <= bus.job_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      job_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      job_ready_q <= (count_nxt != FULL);
    end
  end

  logic [MAX_M_SIZE_LOG2-1:0] head_m;
  logic [MAX_K_SIZE_LOG2-1:0] head_k;
  logic [MAX_N_SIZE_LOG2-1:0] head_n;
  logic                       head_zero;

  assign head_m    = q_m[rd_ptr];
  assign head_k    = q_k[rd_ptr];
  assign head_n    = q_n[rd_ptr];
  assign head_zero = (head_m == '0) || (head_k == '0) || (head_n == '0);

  // ---------------- free-running stall phase ----------------
  logic [STALL_PERIOD_LOG2-1:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else        stall_cnt <= stall_cnt + 1'b1;
  end

  // ---------------- sequencer ----------------
  logic                       start_q, stall_q;
  logic [MAX_M_SIZE_LOG2-1:0] m_q;
  logic [MAX_K_SIZE_LOG2-1:0] k_q;
  logic [MAX_N_SIZE_LOG2-1:0] n_q;
  logic                       dv_q, dto_q;
  logic [ID_W-1:0]            did_q, id_cnt;
  logic [CYC_BWIDTH-1:0]      dcyc_q, total_q, run_cnt;

  logic                  fin, to_hit, run_next, retire_now;
  logic [CYC_BWIDTH-1:0] retire_cyc, total_nxt;
  logic [CYC_BWIDTH:0]   total_sum;

  assign fin      = bus.is_finished;
  assign to_hit   = (run_cnt == TO_VAL);
  assign run_next = ((state == IDLE) && pop && !head_zero) ||
                    ((state == RUN) && !fin && !to_hit);
  // A zero-size job retires straight from IDLE with 0 cycles.
  assign retire_now = ((state == IDLE) && pop && head_zero) ||
                      ((state == RUN) && (fin || to_hit));
  assign retire_cyc = (state == RUN) ? run_cnt : '0;
  assign total_sum  = {1'b0, total_q} + {1'b0, retire_cyc};
  assign total_nxt  = total_sum[CYC_BWIDTH] ? CYC_MAX : total_sum[CYC_BWIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      stall_q <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      dv_q    <= 1'b0;
      did_q   <= '0;
      dcyc_q  <= '0;
      dto_q   <= 1'b0;
      total_q <= '0;
      id_cnt  <= '0;
      run_cnt <= '0;
    end else begin
      dv_q    <= 1'b0;
      // Stall lands on the cycle after the phase counter wraps, RUN only.
      stall_q <= run_next && bus.stall_en && (&stall_cnt);
      case (state)
        IDLE: if (pop) begin
          m_q <= head_m;
          k_q <= head_k;
          n_q <= head_n;
          if (head_zero) begin
            state <= RETIRE;
          end else begin
            state   <= RUN;
            start_q <= 1'b1;
            run_cnt <= CYC_BWIDTH'(1);
          end
        end
        RUN: begin
          if (fin || to_hit) begin
            state   <= RETIRE;
            start_q <= 1'b0;
          end else if (run_cnt != CYC_MAX) begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        RETIRE:  state <= GAP;
        default: state <= IDLE;
      endcase
      if (retire_now) begin
        dv_q    <= 1'b1;
        did_q   <= id_cnt;
        dcyc_q  <= retire_cyc;
        dto_q   <= (state == RUN) && !fin;  // finish beats timeout
        total_q <= total_nxt;
        id_cnt  <= id_cnt + 1'b1;
      end
    end
  end

  assign bus.job_ready    = job_ready_q;
  assign bus.start        = start_q;
  assign bus.stall        = stall_q;
  assign bus.m_size       = m_q;
  assign bus.k_size       = k_q;
  assign bus.n_size       = n_q;
  assign bus.done_valid   = dv_q;
  assign bus.done_id      = did_q;
  assign bus.done_cycles  = dcyc_q;
  assign bus.done_timeout = dto_q;
  assign bus.total_cycles = total_q;
  assign bus.busy         = (state != IDLE) || (count != '0);
endmodule

// File: tb/tb_sa_run_controller.sv
module tb_sa_run_controller;
  localparam int MW = 9, KW = 9, NW = 9, QL = 2, CW = 12, TO = 350, SPL = 3;
  localparam int IDW = QL + 2;
  localparam int TOT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_run_if #(.M_W(MW), .K_W(KW), .N_W(NW), .ID_W(IDW), .CYC_W(CW)) bus ();

  sa_run_controller #(
    .MAX_M_SIZE_LOG2(MW), .MAX_K_SIZE_LOG2(KW), .MAX_N_SIZE_LOG2(NW),
    .QDEPTH_LOG2(QL), .CYC_BWIDTH(CW), .TIMEOUT_CYCLES(TO), .STALL_PERIOD_LOG2(SPL)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int m; int k; int n; int dur; } job_t;
  typedef struct { int id; int cyc; bit to; } dn_t;

  // reference model: job queue + timeline of the active job
  job_t q[$];
  int   now = 0, rcyc = 0;
  bit   active = 0, zero = 0, tmo = 0;
  int   tl = 0, L = 0;
  int   m_e = 0, k_e = 0, n_e = 0;
  int   last_id = 0, last_cyc = 0, total_e = 0, retired = 0;
  bit   last_to = 0, se_prev = 0;

  // stimulus
  bit   s_go = 0, s_se = 0, s_valid = 0, last_acc = 0;
  job_t s_job = '{0, 0, 0, 1};

  dn_t  seen[$];
  int   stall_seen = 0, start_seen = 0;
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0d want %0d", nm, now, act, exp);
    end
  endtask

  task automatic drive_inputs(input bit fin);
    bus.is_finished = fin;
    bus.go          = s_go;
    bus.stall_en    = s_se;
    bus.job_valid   = s_valid;
    bus.job_m       = MW'(s_job.m);
    bus.job_k       = KW'(s_job.k);
    bus.job_n       = NW'(s_job.n);
  endtask

  // One clock: compare outputs of this cycle, drive inputs, advance the model.
  task automatic step();
    bit run_win, dv_e, busy_e, st_e, fin, pop, acc;
    job_t j;
    run_win = active && !zero && now >= tl + 1 && now <= tl + L;
    dv_e    = active && now == tl + L + 1;
    if (dv_e) begin
      last_id  = retired % (1 << IDW);
      last_cyc = L;
      last_to  = tmo;
      total_e  = (total_e + L > TOT_MAX) ? TOT_MAX : total_e + L;
      retired++;
    end
    busy_e = (q.size() > 0) || (active && now >= tl + 1 && now <= tl + L + 2);
    st_e   = run_win && se_prev && (rcyc % (1 << SPL) == 0);

    chk("start", bus.start, run_win);
    chk("stall", bus.stall, st_e);
    chk("done_valid", bus.done_valid, dv_e);
    chk("job_ready", bus.job_ready, q.size() != 4);
    chk("busy", bus.busy, busy_e);
    chk("m_size", bus.m_size, m_e);
    chk("k_size", bus.k_size, k_e);
    chk("n_size", bus.n_size, n_e);
    chk("done_id", bus.done_id, last_id);
    chk("done_cycles", bus.done_cycles, last_cyc);
    chk("done_timeout", bus.done_timeout, last_to);
    chk("total", bus.total_cycles, total_e);

    if (bus.stall === 1'b1) stall_seen++;
    if (bus.start === 1'b1) start_seen++;
    if (bus.done_valid === 1'b1)
      seen.push_back('{int'(bus.done_id), int'(bus.done_cycles), bus.done_timeout});

    // array behaviour: finish on the dur-th RUN cycle; noise outside RUN
    if (run_win) fin = !tmo && (now == tl + L);
    else         fin = ($urandom_range(0, 3) == 0);
    drive_inputs(fin);

    pop = (!active || now >= tl + L + 3) && s_go && q.size() > 0;
    acc = s_valid && q.size() < 4;
    if (pop) begin
      j      = q.pop_front();
      tl     = now;
      active = 1;
      zero   = (j.m == 0) || (j.k == 0) || (j.n == 0);
      if (zero)            begin L = 0;     tmo = 0; end
      else if (j.dur <= TO) begin L = j.dur; tmo = 0; end
      else                 begin L = TO;    tmo = 1; end
      m_e = j.m; k_e = j.k; n_e = j.n;
    end
    if (acc) q.push_back(s_job);
    last_acc = acc;
    se_prev  = s_se;
    now++;
    rcyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_go = 0; s_se = 0; s_valid = 0;
    drive_inputs(1'b0);
    q.delete();
    active = 0; zero = 0; tmo = 0; L = 0;
    m_e = 0; k_e = 0; n_e = 0;
    last_id = 0; last_cyc = 0; last_to = 0; total_e = 0; retired = 0; se_prev = 0;
    repeat (3) @(negedge clk);
    chk("rst_start", bus.start, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_dv", bus.done_valid, 0);
    chk("rst_ready", bus.job_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_total", bus.total_cycles, 0);
    chk("rst_id", bus.done_id, 0);
    rst_n = 1'b1;
    rcyc  = 0;
  endtask

  task automatic push_job(input job_t jb);
    int n = 0;
    s_valid = 1; s_job = jb;
    do begin step(); n++; end while (!last_acc && n < 60);
    s_valid = 0;
    chk("push_bound", n < 60, 1);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((q.size() > 0 || (active && now < tl + L + 3)) && n < maxc) begin
      step(); n++;
    end
    chk("drain_bound", n < maxc, 1);
  endtask

  function automatic job_t rnd_job();
    job_t j; int r;
    j.m = $urandom_range(1, 511);
    j.k = $urandom_range(1, 511);
    j.n = $urandom_range(1, 511);
    if ($urandom_range(0, 9) == 0) begin
      case ($urandom_range(0, 2))
        0: j.m = 0;
        1: j.k = 0;
        default: j.n = 0;
      endcase
    end
    r = $urandom_range(0, 24);
    if (r == 0)      j.dur = TO + $urandom_range(1, 30);
    else if (r == 1) j.dur = TO;
    else             j.dur = $urandom_range(1, 60);
    return j;
  endfunction

  initial begin
    drive_inputs(1'b0);
    @(negedge clk);
    do_reset();

    // 1: single job finishing on RUN cycle 300
    s_go = 1;
    push_job('{128, 128, 128, 300});
    drain(1000);
    chk("t1_id", bus.done_id, 0);
    chk("t1_cycles", bus.done_cycles, 300);
    chk("t1_timeout", bus.done_timeout, 0);
    chk("t1_total", bus.total_cycles, 300);
    chk("t1_model", last_cyc, 300);

    // 2: fill the queue with GO low, fifth push held off
    do_reset();
    seen.delete();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_job = '{10, 10, 10, 10 + i};
      step();
    end
    s_job = '{10, 10, 10, 20};
    chk("t2_ready_full", bus.job_ready, 0);
    step(); step();
    chk("t2_held", last_acc, 0);
    s_go = 1;
    for (int n = 0; n < 30 && !last_acc; n++) step();
    s_valid = 0;
    drain(2000);
    chk("t2_count", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) chk("t2_id", seen[i].id, i);

    // 3: watchdog abort, next job still launches
    seen.delete();
    push_job('{7, 7, 7, TO + 50});
    push_job('{7, 7, 7, 7});
    drain(2000);
    chk("t3_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("t3_cyc0", seen[0].cyc, TO);
      chk("t3_to0", seen[0].to, 1);
      chk("t3_cyc1", seen[1].cyc, 7);
      chk("t3_to1", seen[1].to, 0);
    end

    // 4: stall injection over a 64-cycle job
    seen.delete();
    s_se = 1; stall_seen = 0;
    push_job('{64, 64, 64, 64});
    drain(500);
    s_se = 0;
    chk("t4_stalls", stall_seen, 8);
    chk("t4_cycles", bus.done_cycles, 64);

    // 5: zero-size job, then finish exactly on the timeout cycle
    seen.delete();
    start_seen = 0;
    push_job('{0, 16, 16, 5});
    drain(100);
    chk("t5_nostart", start_seen, 0);
    chk("t5_cyc_zero", bus.done_cycles, 0);
    chk("t5_to_zero", bus.done_timeout, 0);
    push_job('{5, 5, 5, TO});
    drain(1000);
    chk("t5_cyc_edge", bus.done_cycles, TO);
    chk("t5_to_edge", bus.done_timeout, 0);

    // 6: asynchronous reset in the middle of RUN with jobs queued
    push_job('{9, 9, 9, 200});
    push_job('{9, 9, 9, 20});
    push_job('{9, 9, 9, 20});
    repeat (20) step();
    chk("t6_running", bus.start, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_start", bus.start, 0);
    chk("t6_stall", bus.stall, 0);
    chk("t6_dv", bus.done_valid, 0);
    chk("t6_ready", bus.job_ready, 1);
    chk("t6_busy", bus.busy, 0);
    @(negedge clk);
    do_reset();
    seen.delete();
    s_go = 1;
    push_job('{3, 3, 3, 9});
    drain(200);
    chk("t6_count", seen.size(), 1);
    if (seen.size() == 1) begin
      chk("t6_id", seen[0].id, 0);
      chk("t6_cyc", seen[0].cyc, 9);
    end

    // random traffic, long enough to wrap IDs and saturate the total
    for (int i = 0; i < 9000; i++) begin
      if (!s_valid || last_acc) begin
        s_valid = ($urandom_range(0, 2) == 0);
        s_job   = rnd_job();
      end
      s_go = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 63) == 0) s_se = ~s_se;
      step();
    end
    s_valid = 0; s_go = 1;
    drain(5000);
    chk("rand_total_sat", bus.total_cycles, TOT_MAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
